// File: rtl/servo_pwm_bank_pkg.sv
// Shared constants and the pulse-width clamp used by the servo PWM bank.
package servo_pwm_bank_pkg;

   localparam int unsigned US_W           = 15;
   localparam int unsigned US_PER_S       = 1000000;
   localparam int unsigned DEF_FRAME_US   = 20000;
   localparam int unsigned DEF_MIN_US     = 1000;
   localparam int unsigned DEF_MAX_US     = 2000;
   localparam int unsigned DEF_NEUTRAL_US = 1500;

   function automatic logic [US_W-1:0] clamp_us(input logic [15:0] us,
                                                input int unsigned lo,
                                                input int unsigned hi);
      logic [US_W-1:0] r;
      if (32'(us) < lo)
         r = US_W'(lo);
      else if (32'(us) > hi)
         r = US_W'(hi);
      else
         r = us[US_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/servo_us_timebase.sv
// Microsecond timebase: clock prescaler, in-frame us counter and frame wrap strobe.
module servo_us_timebase
   import servo_pwm_bank_pkg::*;
#(
   parameter int unsigned PRE_DIV  = 40,
   parameter int unsigned FRAME_US = DEF_FRAME_US
) (
   input  logic            FAB_CLK,
   input  logic            FAB_RESET,
   output logic [US_W-1:0] us_cnt,
   output logic            frame_tick
);

   localparam int unsigned PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

   logic [PRE_W-1:0] pre;
   logic             us_tick;

   assign us_tick    = (pre == PRE_W'(PRE_DIV - 1));
   assign frame_tick = us_tick && (us_cnt == US_W'(FRAME_US - 1));

   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         pre    <= '0;
         us_cnt <= '0;
      end else begin
         pre <= us_tick ? '0 : pre + 1'b1;
         if (us_tick)
            us_cnt <= frame_tick ? '0 : us_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM generator with double-buffered widths and a
// frame-count watchdog that forces neutral when firmware stops writing.
module servo_pwm_bank
   import servo_pwm_bank_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CLK_HZ      = 40000000,
   parameter int unsigned FRAME_US    = DEF_FRAME_US,
   parameter int unsigned MIN_US      = DEF_MIN_US,
   parameter int unsigned MAX_US      = DEF_MAX_US,
   parameter int unsigned NEUTRAL_US  = DEF_NEUTRAL_US,
   parameter int unsigned WDOG_FRAMES = 25
) (
   input  logic              FAB_CLK,
   input  logic              FAB_RESET,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [3:0]        WR_CH,
   input  logic [15:0]       WR_US,
   output logic              WR_ERR,
   output logic [NUM_CH-1:0] PWM_OUT,
   output logic              FRAME_START,
   output logic              WDOG_TRIP
);

   if (CLK_HZ == 0 || (CLK_HZ % US_PER_S) != 0) begin : g_bad_clk
      $error("CLK_HZ must be a non-zero multiple of 1 MHz");
   end
   if (!(MIN_US <= NEUTRAL_US && NEUTRAL_US <= MAX_US && MAX_US < FRAME_US)) begin : g_bad_us
      $error("require MIN_US <= NEUTRAL_US <= MAX_US < FRAME_US");
   end
   if (NUM_CH < 1 || NUM_CH > 16 || FRAME_US >= (1 << US_W)) begin : g_bad_size
      $error("NUM_CH must be 1..16 and FRAME_US must fit the us counter");
   end

   localparam int unsigned     WD_W      = (WDOG_FRAMES > 0) ? $clog2(WDOG_FRAMES + 1) : 1;
   localparam logic [US_W-1:0] NEUTRAL_W = US_W'(NEUTRAL_US);

   logic [US_W-1:0] us_cnt;
   logic [US_W-1:0] wr_val;
   logic            frame_tick;
   logic            frame_q;
   logic            ch_ok;
   logic            wr_ok;
   logic            trip_next;
   logic [WD_W-1:0] wd_cnt;
   logic [WD_W-1:0] wd_next;

   servo_us_timebase #(
      .PRE_DIV  (CLK_HZ / US_PER_S),
      .FRAME_US (FRAME_US)
   ) u_timebase (
      .FAB_CLK    (FAB_CLK),
      .FAB_RESET  (FAB_RESET),
      .us_cnt     (us_cnt),
      .frame_tick (frame_tick)
   );

   assign WR_READY = !FAB_RESET;
   assign ch_ok    = (32'(WR_CH) < NUM_CH);
   assign wr_ok    = WR_VALID && ch_ok;
   assign wr_val   = clamp_us(WR_US, MIN_US, MAX_US);

   // A valid write beats a coincident frame-start increment.
   always_comb begin
      wd_next   = wd_cnt;
      trip_next = WDOG_TRIP;
      if (wr_ok) begin
         wd_next   = '0;
         trip_next = 1'b0;
      end else if (WDOG_FRAMES != 0 && frame_tick) begin
         if (wd_cnt != WD_W'(WDOG_FRAMES))
            wd_next = wd_cnt + 1'b1;
         if (wd_next == WD_W'(WDOG_FRAMES))
            trip_next = 1'b1;
      end
   end

   // FRAME_START is delayed two cycles so it lines up with the first PWM
   // sample taken from the freshly loaded active widths.
   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         wd_cnt      <= '0;
         WDOG_TRIP   <= 1'b0;
         WR_ERR      <= 1'b0;
         frame_q     <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         wd_cnt      <= wd_next;
         WDOG_TRIP   <= trip_next;
         WR_ERR      <= WR_VALID && !ch_ok;
         frame_q     <= frame_tick;
         FRAME_START <= frame_q;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [US_W-1:0] shadow;
      logic [US_W-1:0] active;
      logic            pwm;

      // trip_next lets the frame start that trips the watchdog load neutral.
      always_ff @(posedge FAB_CLK) begin
         if (FAB_RESET) begin
            shadow <= NEUTRAL_W;
            active <= NEUTRAL_W;
            pwm    <= 1'b0;
         end else begin
            if (wr_ok && WR_CH == 4'(i))
               shadow <= wr_val;
            if (frame_tick)
               active <= trip_next ? NEUTRAL_W : shadow;
            pwm <= (us_cnt < active);
         end
      end

      assign PWM_OUT[i] = pwm;
   end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank on a scaled timebase (1 MHz clock, 200 us frame).
module tb_servo_pwm_bank;

   localparam int unsigned NUM_CH = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [3:0]        wr_ch = '0;
   logic [15:0]       wr_us = '0;
   logic              wr_err;
   logic [NUM_CH-1:0] pwm;
   logic              frame_start;
   logic              wdog_trip;

   servo_pwm_bank #(
      .NUM_CH      (NUM_CH),
      .CLK_HZ      (1000000),
      .FRAME_US    (200),
      .MIN_US      (100),
      .MAX_US      (180),
      .NEUTRAL_US  (150),
      .WDOG_FRAMES (3)
   ) dut (
      .FAB_CLK     (clk),
      .FAB_RESET   (rst),
      .WR_VALID    (wr_valid),
      .WR_READY    (wr_ready),
      .WR_CH       (wr_ch),
      .WR_US       (wr_us),
      .WR_ERR      (wr_err),
      .PWM_OUT     (pwm),
      .FRAME_START (frame_start),
      .WDOG_TRIP   (wdog_trip)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      bit         wr;
      logic [3:0] ch;
      logic [15:0] us;
      logic [1:0] pwm;
      logic       fs;
      logic       trip;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   t;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run_to(input int target);
      while (t < target) step();
   endtask

   task automatic check(input string name, input int at, input logic [4:0] act,
                        input logic [4:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%b expected=%b", name, at, act, exp);
      end
   endtask

   task automatic write_at(input int at, input logic [3:0] ch, input logic [15:0] us);
      run_to(at - 1);
      wr_valid = 1'b1;
      wr_ch    = ch;
      wr_us    = us;
      step();
      wr_valid = 1'b0;
   endtask

   function automatic vec_t ck(input int tt, input logic [1:0] p, input logic fs,
                               input logic trip, input logic err);
      vec_t v;
      v.t = tt; v.wr = 1'b0; v.ch = '0; v.us = '0;
      v.pwm = p; v.fs = fs; v.trip = trip; v.err = err;
      return v;
   endfunction

   function automatic vec_t wv(input int tt, input logic [3:0] ch, input logic [15:0] us);
      vec_t v;
      v.t = tt; v.wr = 1'b1; v.ch = ch; v.us = us;
      v.pwm = '0; v.fs = 1'b0; v.trip = 1'b0; v.err = 1'b0;
      return v;
   endfunction

   initial begin
      int hi0, hi1, nfs;

      // Outputs are {PWM_OUT[1], PWM_OUT[0]}; edge index t counts from reset release.
      vecs.push_back(ck(0,    2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(149,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(150,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(199,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(200,  2'b11, 1'b1, 1'b0, 1'b0));
      vecs.push_back(ck(201,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(349,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(350,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(598,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(599,  2'b00, 1'b0, 1'b1, 1'b0));
      vecs.push_back(wv(650,  4'd1, 16'd120));
      vecs.push_back(ck(651,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(749,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(750,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(919,  2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(920,  2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(949,  2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(950,  2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(wv(1050, 4'd0, 16'd0));
      vecs.push_back(ck(1051, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1299, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1300, 2'b10, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1319, 2'b10, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1320, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(wv(1350, 4'd0, 16'hFFFF));
      vecs.push_back(ck(1519, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1520, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1579, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1580, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(wv(1650, 4'd2, 16'd170));
      vecs.push_back(ck(1650, 2'b11, 1'b0, 1'b0, 1'b1));
      vecs.push_back(ck(1651, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1798, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1799, 2'b00, 1'b0, 1'b1, 1'b0));
      vecs.push_back(ck(1849, 2'b11, 1'b0, 1'b1, 1'b0));
      vecs.push_back(wv(1850, 4'd0, 16'd170));
      vecs.push_back(ck(1850, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1949, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(1950, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2119, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2120, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2169, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2170, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(wv(2199, 4'd1, 16'd160));
      vecs.push_back(ck(2200, 2'b11, 1'b1, 1'b0, 1'b0));
      vecs.push_back(ck(2319, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2320, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(wv(2450, 4'd0, 16'd110));
      vecs.push_back(wv(2451, 4'd0, 16'd130));
      vecs.push_back(ck(2519, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2559, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2560, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2569, 2'b01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2570, 2'b00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2729, 2'b11, 1'b0, 1'b0, 1'b0));
      vecs.push_back(ck(2730, 2'b10, 1'b0, 1'b0, 1'b0));

      // Reset state
      t = 0;
      repeat (3) step();
      check("reset_outputs", t, {pwm, frame_start, wdog_trip, wr_err}, 5'b00000);
      check("reset_ready", t, {4'b0000, wr_ready}, 5'b00000);

      rst = 1'b0;
      t = -1;
      step();
      check("ready_after_release", t, {4'b0000, wr_ready}, 5'b00001);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            write_at(vecs[i].t, vecs[i].ch, vecs[i].us);
         end else begin
            run_to(vecs[i].t);
            check("vec", t, {pwm, frame_start, wdog_trip, wr_err},
                  {vecs[i].pwm, vecs[i].fs, vecs[i].trip, vecs[i].err});
         end
      end

      // Mid-frame reset aborts the frame and restores neutral widths
      rst = 1'b1;
      #1;
      check("ready_in_reset", t, {4'b0000, wr_ready}, 5'b00000);
      step();
      check("midframe_reset", t, {pwm, frame_start, wdog_trip, wr_err}, 5'b00000);
      step();
      rst = 1'b0;
      t = -1;
      step();
      check("post_reset_t0", t, {pwm, frame_start, wdog_trip, wr_err}, 5'b11000);
      run_to(149);
      check("post_reset_t149", t, {pwm, frame_start, wdog_trip, wr_err}, 5'b11000);
      run_to(150);
      check("post_reset_t150", t, {pwm, frame_start, wdog_trip, wr_err}, 5'b00000);

      // One full frame: exact high time and a single frame-start pulse
      run_to(199);
      hi0 = 0; hi1 = 0; nfs = 0;
      repeat (200) begin
         step();
         hi0 += int'(pwm[0]);
         hi1 += int'(pwm[1]);
         nfs += int'(frame_start);
      end
      n_tests++;
      if (hi0 != 150 || hi1 != 150 || nfs != 1) begin
         n_fail++;
         $display("FAIL frame_measure got hi0=%0d hi1=%0d fs=%0d expected 150 150 1",
                  hi0, hi1, nfs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
